// File: rtl/pe_stream_pkg.sv
// Shared types and constants for the PE stream arbiter slice.
package pe_stream_pkg;
  localparam int DATA_W        = 64;
  localparam int LEN_W_DEFAULT = 16;
  localparam int HDR_LEN_LSB   = 0;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;
endpackage

// File: rtl/pe_arb_fifo.sv
// Synchronous first-word-fall-through skid FIFO with occupancy-based almost-full.
module pe_arb_fifo
  import pe_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SLACK = 4
) (
  input  logic                   CLK,
  input  logic                   SYS_RST_N,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      din,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   afull,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, wr_ok, rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so writing into a full FIFO is legal then.
  assign wr_ok    = wr_en & (~full | rd_ok);
  assign overflow = wr_en & ~wr_ok;

  assign dout      = mem[rd_ptr];
  assign occupancy = count;
  assign afull     = (count >= CW'(DEPTH - SLACK));

  // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (!SYS_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end
endmodule

// File: rtl/pe_stream_arbiter.sv
// Packet-granular round-robin 2:1 arbiter merging two PE streams onto one D/D_VALID/D_BP port.
module pe_stream_arbiter
  import pe_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SLACK = 4,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              SYS_RST_N,
  input  logic [DATA_W-1:0] D,
  input  logic              D_VALID,
  output logic              D_BP,
  input  logic [DATA_W-1:0] D2,
  input  logic              D2_VALID,
  output logic              D2_BP,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              Q_SRC,
  input  logic              Q_BP,
  output logic              ERR
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        in_v;
  logic [DATA_W-1:0] in_d [2];
  logic [DATA_W-1:0] dout [2];
  logic [CW-1:0]     occ0, occ1;
  logic [1:0]        empty, afull, ovf, pop;

  arb_state_t        state;
  logic              ptr, gnt_q, gnt;
  logic [LEN_W-1:0]  remaining, hdr_len;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!SYS_RST_N) in_v <= '0;
    else            in_v <= {D2_VALID, D_VALID};
  end

  always_ff @(posedge CLK) begin
    in_d[0] <= D;
    in_d[1] <= D2;
  end

  pe_arb_fifo #(.DEPTH(DEPTH), .SLACK(SLACK)) u_fifo0 (
    .CLK(CLK), .SYS_RST_N(SYS_RST_N), .wr_en(in_v[0]), .din(in_d[0]), .rd_en(pop[0]),
    .dout(dout[0]), .empty(empty[0]), .occupancy(occ0), .afull(afull[0]), .overflow(ovf[0])
  );

  pe_arb_fifo #(.DEPTH(DEPTH), .SLACK(SLACK)) u_fifo1 (
    .CLK(CLK), .SYS_RST_N(SYS_RST_N), .wr_en(in_v[1]), .din(in_d[1]), .rd_en(pop[1]),
    .dout(dout[1]), .empty(empty[1]), .occupancy(occ1), .afull(afull[1]), .overflow(ovf[1])
  );

  assign D_BP  = afull[0];
  assign D2_BP = afull[1];

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    gnt = gnt_q;
    if (state == IDLE) gnt = (empty == 2'b00) ? ptr : empty[0];
  end

  assign Q       = dout[gnt];
  assign Q_VALID = ~empty[gnt] & ~Q_BP;
  assign Q_SRC   = Q_VALID & gnt;
  assign pop     = {Q_VALID & gnt, Q_VALID & ~gnt};
  assign hdr_len = Q[HDR_LEN_LSB +: LEN_W];

  always_ff @(posedge CLK) begin
    if (!SYS_RST_N) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      gnt_q     <= 1'b0;
      remaining <= '0;
      ERR       <= 1'b0;
    end else begin
      ERR <= ERR | (|ovf);
      case (state)
        IDLE: if (Q_VALID) begin
          if (hdr_len == '0) begin
            ptr <= ~gnt;
          end else begin
            gnt_q     <= gnt;
            remaining <= hdr_len;
            state     <= XFER;
          end
        end
        XFER: if (Q_VALID) begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= IDLE;
            ptr   <= ~gnt_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_occ_bound: assert property (@(posedge CLK) disable iff (!SYS_RST_N)
    (occ0 <= CW'(DEPTH)) && (occ1 <= CW'(DEPTH)));
endmodule

// File: doc/pe_stream_arbiter.md
Name: pe_stream_arbiter

Overview:
- Round-robin, packet-granular 2:1 arbiter that shares one PE input stream between two upstream sources (D and D2).
- Sits between the router/host stream ports and a single-input PE wrapper.
- Merges packets onto the PE's D/D_VALID/D_BP interface and never interleaves words of different packets.
- Each input has a small FWFT skid FIFO, so the advisory, latency-tolerant BP semantics used throughout the PE fabric are honoured.

Parameters:
- DEPTH, 16, words per input skid FIFO (power of 2, >= 8).
- SLACK, 4, free entries still available when Dn_BP asserts; absorbs upstream BP latency.
- LEN_W, 16, width of the header length field.

Ports:
- CLK  in  1  clock.
- SYS_RST_N  in  1  synchronous reset, active-low.
- D  in  64  input 0 data.
- D_VALID  in  1  input 0 word valid.
- D_BP  out  1  input 0 backpressure, active-high.
- D2  in  64  input 1 data.
- D2_VALID  in  1  input 1 word valid.
- D2_BP  out  1  input 1 backpressure.
- Q  out  64  merged output data.
- Q_VALID  out  1  output word transferred this cycle.
- Q_SRC  out  1  source index of the current Q word.
- Q_BP  in  1  downstream backpressure, honoured same-cycle.
- ERR  out  1  sticky overflow flag.

Behaviour:
- Reset (SYS_RST_N=0 at a CLK edge):
  - Both FIFOs flushed; state=IDLE; remaining count=0; priority pointer favours input 0.
  - ERR=0, Q_VALID=0, D_BP=D2_BP=0, Q_SRC=0.
  - Reset mid-packet discards the partial packet with no further output.
- Input stage:
  - Dn/Dn_VALID are registered once, then written to FIFO n when the registered valid is 1.
  - A write while FIFO n is full drops the word and sets ERR (sticky until reset).
- Backpressure: Dn_BP = (occupancy_n >= DEPTH-SLACK), combinational from the occupancy counter.
- Packet format:
  - The first word of each packet is the header; header[LEN_W-1:0] = number of payload words that follow.
  - LEN=0 means a header-only packet. All 64 header bits pass through unmodified.
- Output:
  - Q = head of the granted FIFO.
  - Q_VALID = granted FIFO non-empty & ~Q_BP & (state permits).
  - A word is popped exactly when Q_VALID=1.
  - Q_SRC = grant index, valid whenever Q_VALID=1.
- FSM, IDLE:
  - Candidates are the inputs whose FIFO is non-empty; each head is by definition a header.
  - Both candidates present: grant the input the pointer favours. One candidate: grant it.
  - If ~Q_BP, emit the header.
    - LEN=0: remain IDLE and toggle the pointer to favour the other input.
    - LEN>0: load remaining=LEN and go to XFER.
  - If Q_BP=1, no grant is latched; arbitration is re-evaluated next cycle.
- FSM, XFER:
  - Grant is frozen.
  - Each cycle with granted FIFO non-empty & ~Q_BP: emit the word and decrement remaining.
  - When remaining reaches 0 after the emit, return to IDLE and set the pointer to favour the non-granted input.
  - An empty granted FIFO mid-packet stalls with Q_VALID=0. The other input is never serviced during XFER.
- Latency: D_VALID at cycle n → Q_VALID earliest at cycle n+2 (register + FWFT), when idle and Q_BP=0.
- Throughput: 1 word/cycle sustained, including back-to-back packets (no idle cycle between packets).
- Simultaneous events: a FIFO write and pop in the same cycle leave occupancy unchanged. Pushing into the full FIFO while it pops is allowed (not an overflow).
- Width rules:
  - remaining is LEN_W bits; LEN=2^LEN_W-1 is legal.
  - Occupancy counters are log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.

Decomposition:
- Shared package pe_stream_pkg:
  - HDR_LEN_LSB=0.
  - LEN_W default.
  - State enum {IDLE, XFER}.
  - DATA_W=64.
- Sub-module pe_arb_fifo: sync FWFT FIFO with DATA_W, DEPTH, SLACK; outputs dout, empty, occupancy, afull, overflow.
  - Instantiated twice.
  - Arbiter FSM and output mux remain in the top.

Test Plan:
- Single packet on D: header LEN=3 + 3 words, Q_BP=0 → Q_VALID high cycles n+2..n+5, words in order, Q_SRC=0, ERR=0.
- Simultaneous packets: D (LEN=2) and D2 (LEN=2) both arrive at cycle 0 after reset → D's 3 words, then D2's 3 words back-to-back with no gap, Q_SRC 0,0,0,1,1,1.
- Fairness: both inputs stream continuous LEN=0 headers → Q_SRC alternates 0,1,0,1… every cycle.
- Backpressure: DEPTH=16, SLACK=4, Q_BP=1 held, D sends 20 words → D_BP asserts the cycle occupancy hits 12. Upstream stops within 4 cycles: 16 words stored, ERR=0. Upstream continues to 17 words → ERR=1 and the 17th word is lost.
- Stall mid-packet: D header LEN=4, payload words 2–4 delayed 5 cycles while D2 holds a full packet → Q_VALID=0 during the gap, D2 is not granted until D's packet completes.
- Reset mid-packet: SYS_RST_N=0 for one cycle during D XFER with remaining=2 → next cycle Q_VALID=0, D_BP=0, ERR=0. A new D2 header LEN=0 afterwards emits with Q_SRC=1.
